// File: rtl/hazard_pkg.sv
// Shared types for the 5-stage pipeline hazard controller.
// Optional performance counters in hazard_ctrl are enabled by HAZARD_PERF_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding select for the EX stage; MEM result beats WB result.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  output fwd_sel_t   fwd
);

  // x0 is hardwired zero, so it is never a forwarding target.
  always_comb begin
    fwd = FWD_RF;
    if (ex_rs != 5'd0) begin
      if (mem_reg_write && (mem_rd == ex_rs)) begin
        fwd = FWD_MEM;
      end else if (wb_reg_write && (wb_rd == ex_rs)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use stalls, branch flushes and data-memory wait stalls.
// Define HAZARD_PERF_EN to add the stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_pc_src,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             if_stall,
  output logic             de_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             de_flush,
  output logic             ex_clear,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
`endif
  output logic             mem_timeout
);

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  fwd_sel_t fwd_a_sel, fwd_b_sel;
  logic     lw_hazard;
  logic     stall_all, lw_stall, flush, clear;

  fwd_select u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_b_sel)
  );

  assign lw_hazard = (ex_result_src == RESULT_SRC_LOAD) && (ex_rd != 5'd0) &&
                     ((ex_rd == de_rs1) || (ex_rd == de_rs2));

  always_comb begin
    state_d       = state_q;
    flush_pend_d  = flush_pend_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_all     = 1'b0;
    lw_stall      = 1'b0;
    flush         = 1'b0;
    clear         = 1'b0;
    case (state_q)
      RUN: begin
        // A branch resolving on the stall-entry cycle is held until the wait ends.
        if (mem_req && !mem_ready) begin
          stall_all    = 1'b1;
          state_d      = MEM_WAIT;
          flush_pend_d = ex_pc_src;
          wait_cnt_d   = '0;
        end else if (ex_pc_src) begin
          flush = 1'b1;
          clear = 1'b1;
        end else if (lw_hazard) begin
          lw_stall = 1'b1;
          clear    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d      = RUN;
          wait_cnt_d   = '0;
          flush_pend_d = 1'b0;
          if (flush_pend_q || ex_pc_src) begin
            flush = 1'b1;
            clear = 1'b1;
          end
        end else begin
          stall_all = 1'b1;
          if (ex_pc_src) begin
            flush_pend_d = 1'b1;
          end
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (wait_cnt_d == WAIT_MAX) begin
            mem_timeout_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_pend_q  <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_pend_q  <= flush_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Every output is held low while reset is asserted.
  assign fwd_a       = rst_n ? fwd_a_sel : 2'b00;
  assign fwd_b       = rst_n ? fwd_b_sel : 2'b00;
  assign if_stall    = rst_n & (stall_all | lw_stall);
  assign de_stall    = rst_n & (stall_all | lw_stall);
  assign ex_stall    = rst_n & stall_all;
  assign mem_stall   = rst_n & stall_all;
  assign de_flush    = rst_n & flush;
  assign ex_clear    = rst_n & clear;
  assign mem_timeout = rst_n & mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [CNT_W-1:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + CNT_W'(if_stall);
    perf_flush_cnt_d = perf_flush_cnt_q + CNT_W'(de_flush);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand sequences and randomized traffic vs a behavioural model.
module tb_hazard_ctrl;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0] ex_result_src;
  logic       ex_pc_src, mem_reg_write, wb_reg_write, mem_req, mem_ready;
  logic [1:0] fwd_a, fwd_b;
  logic       if_stall, de_stall, ex_stall, mem_stall, de_flush, ex_clear, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .if_stall(if_stall), .de_stall(de_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .de_flush(de_flush), .ex_clear(ex_clear),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit m_wait, m_pend, m_to;
  int m_cnt;
  int m_pstall, m_pflush;
  logic [1:0] e_fa, e_fb;
  logic e_ifs, e_des, e_exs, e_mems, e_fl, e_clr, e_to;
  // Sampled DUT outputs
  logic [1:0] s_fa, s_fb;
  logic s_ifs, s_des, s_exs, s_mems, s_fl, s_clr, s_to;

  typedef struct {
    logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd;
    logic [1:0] rsrc;
    logic       pc;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_we, wb_we, req, rdy;
    logic [1:0] ea, eb;
    logic       ifs, des, exs, mems, fl, clr;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (mem_reg_write && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_expect();
    bit lw;
    {e_fa, e_fb, e_ifs, e_des, e_exs, e_mems, e_fl, e_clr, e_to} = '0;
    if (rst_n) begin
      e_fa = ref_fwd(ex_rs1);
      e_fb = ref_fwd(ex_rs2);
      e_to = m_to;
      lw = (ex_result_src == 2'b01) && ex_rd != 0 && (ex_rd == de_rs1 || ex_rd == de_rs2);
      if ((!m_wait && mem_req && !mem_ready) || (m_wait && !mem_ready)) begin
        {e_ifs, e_des, e_exs, e_mems} = 4'b1111;
      end else if (m_wait) begin
        e_fl = m_pend || ex_pc_src;
        e_clr = e_fl;
      end else begin
        e_fl = ex_pc_src;
        e_ifs = lw && !ex_pc_src;
        e_des = e_ifs;
        e_clr = lw || ex_pc_src;
      end
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_wait = 0; m_pend = 0; m_to = 0; m_cnt = 0; m_pstall = 0; m_pflush = 0;
    end else begin
      m_pstall += int'(e_ifs);
      m_pflush += int'(e_fl);
      if (!m_wait) begin
        if (mem_req && !mem_ready) begin
          m_wait = 1; m_pend = ex_pc_src; m_cnt = 0;
        end
      end else if (mem_ready) begin
        m_wait = 0; m_pend = 0; m_cnt = 0;
      end else begin
        m_pend = m_pend || ex_pc_src;
        m_cnt++;
        if (m_cnt >= TO) m_to = 1;
      end
    end
  endtask

  task automatic cyc(input string nm);
    @(negedge clk);
    model_expect();
    {s_fa, s_fb, s_ifs, s_des, s_exs, s_mems, s_fl, s_clr, s_to} =
      {fwd_a, fwd_b, if_stall, de_stall, ex_stall, mem_stall, de_flush, ex_clear, mem_timeout};
    chk({nm, ".fwd_a"}, 32'(s_fa), 32'(e_fa));
    chk({nm, ".fwd_b"}, 32'(s_fb), 32'(e_fb));
    chk({nm, ".if_stall"}, 32'(s_ifs), 32'(e_ifs));
    chk({nm, ".de_stall"}, 32'(s_des), 32'(e_des));
    chk({nm, ".ex_stall"}, 32'(s_exs), 32'(e_exs));
    chk({nm, ".mem_stall"}, 32'(s_mems), 32'(e_mems));
    chk({nm, ".de_flush"}, 32'(s_fl), 32'(e_fl));
    chk({nm, ".ex_clear"}, 32'(s_clr), 32'(e_clr));
    chk({nm, ".mem_timeout"}, 32'(s_to), 32'(e_to));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    {de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    ex_result_src = 2'b00;
    {ex_pc_src, mem_reg_write, wb_reg_write, mem_req, mem_ready} = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc("reset");
    cyc("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0,0,5,0,0,2'd0,0,5,5,1,1,0,0, 2'd2,2'd0, 0,0,0,0,0,0};
    tbl[1]  = '{0,0,5,0,0,2'd0,0,5,5,0,1,0,0, 2'd1,2'd0, 0,0,0,0,0,0};
    tbl[2]  = '{0,0,0,0,0,2'd0,0,0,0,1,1,0,0, 2'd0,2'd0, 0,0,0,0,0,0};
    tbl[3]  = '{0,0,3,9,0,2'd0,0,9,3,1,1,0,0, 2'd1,2'd2, 0,0,0,0,0,0};
    tbl[4]  = '{0,7,0,0,7,2'd1,0,0,0,0,0,0,0, 2'd0,2'd0, 1,1,0,0,0,1};
    tbl[5]  = '{0,0,0,0,0,2'd1,0,0,0,0,0,0,0, 2'd0,2'd0, 0,0,0,0,0,0};
    tbl[6]  = '{7,0,0,0,7,2'd0,0,0,0,0,0,0,0, 2'd0,2'd0, 0,0,0,0,0,0};
    tbl[7]  = '{7,0,0,0,7,2'd1,1,0,0,0,0,0,0, 2'd0,2'd0, 0,0,0,0,1,1};
    tbl[8]  = '{0,0,0,0,0,2'd0,1,0,0,0,0,0,0, 2'd0,2'd0, 0,0,0,0,1,1};
    tbl[9]  = '{0,0,0,0,0,2'd0,0,0,0,0,0,1,1, 2'd0,2'd0, 0,0,0,0,0,0};
    tbl[10] = '{0,7,0,0,7,2'd1,0,0,0,0,0,1,0, 2'd0,2'd0, 1,1,1,1,0,0};
    tbl[11] = '{0,0,0,0,0,2'd0,0,0,0,0,0,1,1, 2'd0,2'd0, 0,0,0,0,0,0};
    tbl[12] = '{0,0,4,4,0,2'd0,0,4,4,0,0,0,0, 2'd0,2'd0, 0,0,0,0,0,0};

    idle();
    rst_n = 1'b0;
    mem_req = 1'b1;
    ex_pc_src = 1'b1;
    cyc("in_reset");
    chk("reset.if_stall", 32'(s_ifs), 0);
    chk("reset.de_flush", 32'(s_fl), 0);
    idle();
    do_reset();

    foreach (tbl[i]) begin
      de_rs1 = tbl[i].de_rs1; de_rs2 = tbl[i].de_rs2;
      ex_rs1 = tbl[i].ex_rs1; ex_rs2 = tbl[i].ex_rs2; ex_rd = tbl[i].ex_rd;
      ex_result_src = tbl[i].rsrc; ex_pc_src = tbl[i].pc;
      mem_rd = tbl[i].mem_rd; wb_rd = tbl[i].wb_rd;
      mem_reg_write = tbl[i].mem_we; wb_reg_write = tbl[i].wb_we;
      mem_req = tbl[i].req; mem_ready = tbl[i].rdy;
      cyc($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.fwd_a", i), 32'(s_fa), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d.fwd_b", i), 32'(s_fb), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d.stalls", i), 32'({s_ifs, s_des, s_exs, s_mems}),
          32'({tbl[i].ifs, tbl[i].des, tbl[i].exs, tbl[i].mems}));
      chk($sformatf("tbl%0d.flush_clear", i), 32'({s_fl, s_clr}), 32'({tbl[i].fl, tbl[i].clr}));
    end

    // Load-use: one stall cycle, then the bubble removes the hazard
    idle();
    ex_result_src = 2'b01; ex_rd = 5'd7; de_rs2 = 5'd7;
    cyc("lu1");
    chk("lu1.if_stall", 32'(s_ifs), 1);
    ex_result_src = 2'b00; ex_rd = 5'd0;
    cyc("lu2");
    chk("lu2.if_stall", 32'(s_ifs), 0);
    chk("lu2.ex_clear", 32'(s_clr), 0);

    // 3-cycle memory wait with a branch resolving mid-wait
    idle();
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_pc_src = (i == 1);
      cyc($sformatf("mw%0d", i));
      chk($sformatf("mw%0d.stalls", i), 32'({s_ifs, s_des, s_exs, s_mems}), 32'hf);
      chk($sformatf("mw%0d.de_flush", i), 32'(s_fl), 0);
    end
    ex_pc_src = 1'b0;
    mem_ready = 1'b1;
    cyc("mw_ready");
    chk("mw_ready.stalls", 32'({s_ifs, s_des, s_exs, s_mems}), 0);
    chk("mw_ready.flush_clear", 32'({s_fl, s_clr}), 32'h3);
    idle();
    cyc("mw_after");
    chk("mw_after.de_flush", 32'(s_fl), 0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 3);
    chk("perf_flush_cnt", perf_flush_cnt, 1);
`endif

    // Timeout: mem_ready held low past the limit
    idle();
    mem_req = 1'b1;
    for (int i = 0; i < TO + 2; i++) cyc("to_wait");
    mem_ready = 1'b1;
    cyc("to_ready");
    chk("to.sticky", 32'(s_to), 1);
    idle();
    cyc("to_idle");
    chk("to.held", 32'(s_to), 1);
    rst_n = 1'b0;
    mem_req = 1'b1;
    cyc("to_rst");
    chk("to_rst.stalls", 32'({s_ifs, s_des, s_exs, s_mems}), 0);
    rst_n = 1'b1;
    idle();
    cyc("to_post");
    chk("to_post.mem_timeout", 32'(s_to), 0);

    // Reset in the middle of a wait discards the pending flush
    mem_req = 1'b1;
    ex_pc_src = 1'b1;
    cyc("rw0");
    ex_pc_src = 1'b0;
    cyc("rw1");
    rst_n = 1'b0;
    cyc("rw_rst");
    rst_n = 1'b1;
    mem_req = 1'b0;
    mem_ready = 1'b1;
    cyc("rw_post");
    chk("rw_post.de_flush", 32'(s_fl), 0);

    // Randomized traffic
    idle();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      de_rs1 = 5'($urandom_range(0, 3)); de_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      ex_result_src = 2'($urandom_range(0, 3));
      ex_pc_src = ($urandom_range(0, 5) == 0);
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write = 1'($urandom_range(0, 1));
      mem_req = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      cyc("rand");
    end
`ifdef HAZARD_PERF_EN
    chk("rand.perf_stall_cnt", perf_stall_cnt, 32'(m_pstall));
    chk("rand.perf_flush_cnt", perf_flush_cnt, 32'(m_pflush));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
